// File: rtl/hash_io_bridge.sv
// -----------------------------------------------------------------------------
// hash_io_bridge
//
// Host-side bridge between a narrow DW-bit word bus and a wide hash core.
// It packs MSG_BEATS host words into one MSG_W-bit block. The first word
// received becomes the most significant word. When the block is complete it
// issues a one-cycle start pulse to the core and then waits for the core to
// finish. On request it captures the core's HASH_W-bit digest and streams it
// back out as HASH_BEATS words over a valid/ready handshake.
//
// Compile-time option:
//   OUT_LSW_FIRST_EN  when defined, the digest is read out least significant
//                     word first. When undefined (the default), it is read out
//                     most significant word first. The macro does not change
//                     the order in which message words are assembled.
//
// Parameters:
//   DW      host word width
//   MSG_W   message block width (multiple of DW)
//   HASH_W  digest width (multiple of DW)
//
// Ports:
//   i_clk     clock, all logic on the rising edge
//   i_rst_n   synchronous active-low reset
//   i_load    host word on i_idata is valid this cycle
//   i_idata   host message word, most significant word of the block first
//   i_fetch   host requests a digest readout (level; retried while core busy)
//   i_ordy    host ready to take o_odata
//   o_odata   digest word (zero when o_ovalid is low)
//   o_ovalid  o_odata valid
//   o_ack     one-cycle pulse the cycle after each accepted message word
//   o_msg     assembled block to the core; held stable outside message loading
//   o_start   one-cycle core start pulse
//   i_busy    core busy; asserted by the core the cycle after it samples start
//   i_hash    core digest, valid whenever i_busy is low
//   o_done    one-cycle pulse when the core drops busy after a start
// -----------------------------------------------------------------------------
module hash_io_bridge #(
    parameter int DW     = 16,
    parameter int MSG_W  = 512,
    parameter int HASH_W = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DW-1:0]     i_idata,
    input  logic              i_fetch,
    input  logic              i_ordy,
    output logic [DW-1:0]     o_odata,
    output logic              o_ovalid,
    output logic              o_ack,
    output logic [MSG_W-1:0]  o_msg,
    output logic              o_start,
    input  logic              i_busy,
    input  logic [HASH_W-1:0] i_hash,
    output logic              o_done
);

    localparam int MSG_BEATS  = MSG_W / DW;
    localparam int HASH_BEATS = HASH_W / DW;
    localparam int MAX_BEATS  = (MSG_BEATS > HASH_BEATS) ? MSG_BEATS : HASH_BEATS;
    // A single-beat configuration still needs a 1-bit counter to be legal.
    localparam int CW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [CW-1:0] MSG_LAST  = CW'(MSG_BEATS - 1);
    localparam logic [CW-1:0] HASH_LAST = CW'(HASH_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [MSG_W-1:0]    r_msg;
    logic [HASH_W-1:0]   r_hash;
    logic                r_ack;
    logic                r_start;
    logic                r_done;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_count_nxt;
    logic [MSG_W-1:0]    w_msg_nxt;
    logic [HASH_W-1:0]   w_hash_nxt;
    logic                w_ack_nxt;
    logic                w_start_nxt;
    logic                w_done_nxt;
    logic [MSG_W-1:0]    w_msg_shift;
    logic [DW-1:0]       w_word;

    // Block with the incoming word shifted in at the bottom. A single-beat
    // block has nothing to shift, so the new word replaces it outright.
    generate
        if (MSG_BEATS == 1) begin : g_shift_one
            assign w_msg_shift = i_idata;
        end else begin : g_shift_many
            assign w_msg_shift = {r_msg[MSG_W-DW-1:0], i_idata};
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_msg_nxt   = r_msg;
        w_hash_nxt  = r_hash;
        w_ack_nxt   = 1'b0;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // A new message word wins over a readout request.
                if (i_load) begin
                    w_msg_nxt = w_msg_shift;
                    w_ack_nxt = 1'b1;
                    if (MSG_BEATS == 1) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_count_nxt = CW'(1);
                        w_state_nxt = S_LOAD;
                    end
                end else if (i_fetch && !i_busy) begin
                    // The digest is captured once here. Later changes on
                    // i_hash do not disturb a readout that is in progress.
                    w_hash_nxt  = i_hash;
                    w_count_nxt = '0;
                    w_state_nxt = S_OUT;
                end
            end

            S_LOAD: begin
                // When load is low the bridge stalls indefinitely.
                if (i_load) begin
                    w_msg_nxt = w_msg_shift;
                    w_ack_nxt = 1'b1;
                    if (r_count == MSG_LAST) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end

            S_ARM: begin
                if (!i_busy) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // The core raises busy only in the cycle after it has seen
                // start, so busy is still low while start is high. That low
                // value must not be taken as completion.
                if (!r_start && !i_busy) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_OUT: begin
                if (i_ordy) begin
                    if (r_count == HASH_LAST) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_msg   <= '0;
            r_hash  <= '0;
            r_ack   <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_msg   <= w_msg_nxt;
            r_hash  <= w_hash_nxt;
            r_ack   <= w_ack_nxt;
            r_start <= w_start_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Digest word select; the readout order is chosen at compile time
    // ---------------------------------------------------------------------
    always_comb begin
        w_word = '0;
        if (r_state == S_OUT) begin
`ifdef OUT_LSW_FIRST_EN
            w_word = r_hash[int'(r_count)*DW +: DW];
`else
            w_word = r_hash[(HASH_BEATS - 1 - int'(r_count))*DW +: DW];
`endif
        end
    end

    assign o_ovalid = (r_state == S_OUT);
    assign o_odata  = w_word;
    assign o_ack    = r_ack;
    assign o_msg    = r_msg;
    assign o_start  = r_start;
    assign o_done   = r_done;

endmodule
